serializer16: RTL and testbench
===============================

# serializer16

Sequential parallel-to-serial stage that accepts a 16-bit word over a valid/ready handshake and emits it one bit per transfer. The block owns the 4-bit bit-index counter that drives the select of the existing `mux16_1` bit-select mux, so it sits directly upstream of that mux and wraps it. The serial output carries its own valid/ready handshake with a last-bit flag, so downstream logic can stall the stream.

## Interface
- `MSB_FIRST`, default 0: 0 emits bit 0 first; 1 emits bit 15 first.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 16: parallel word to serialize.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block will accept a word this cycle.
- `ser_out` output 1: current serial bit.
- `ser_valid` output 1: `ser_out` is valid.
- `ser_ready` input 1: downstream accepts `ser_out` this cycle.
- `ser_last` output 1: current bit is the final bit of the word.

## Operation
- Registers:
  - `hold[15:0]`: the captured word.
  - `cnt[3:0]`: the bit index.
  - `state`: one of IDLE or SHIFT.
- Reset (`rst`=1 at an edge) sets:
  - `state`=IDLE, `cnt`=0, `hold`=0.
  - Following outputs: `ser_valid`=0, `ser_last`=0, `ser_out`=0, `in_ready`=1.
- Word accept occurs when `in_valid` & `in_ready` at an edge:
  - `hold` ← `in_data`.
  - `cnt` ← 0 (`MSB_FIRST`=0) or 15 (`MSB_FIRST`=1).
  - `state` ← SHIFT.
- Bit transfer occurs when `ser_valid` & `ser_ready` at an edge.
- IDLE:
  - `in_ready`=1, `ser_valid`=0.
  - IDLE → SHIFT on word accept.
- SHIFT:
  - `ser_valid`=1.
  - `ser_out` = `hold[cnt]`, selected through `mux16_1` with `s`=`cnt`.
  - On a bit transfer, `cnt` increments (`MSB_FIRST`=0) or decrements (`MSB_FIRST`=1).
  - If no transfer occurs (`ser_ready`=0), `cnt`, `hold` and `ser_out` hold stable.
- `ser_last`:
  - `ser_last` = SHIFT & (`cnt`==15 for `MSB_FIRST`=0, `cnt`==0 for `MSB_FIRST`=1).
  - The terminal index is never wrapped past. A transfer on the last bit ends the word.
- End of word (last-bit transfer):
  - With `in_valid`=1 in the same cycle, the new word is accepted: state stays SHIFT and `cnt` reloads.
  - Otherwise SHIFT → IDLE.
- `in_ready` = (state==IDLE) | (`ser_last` & `ser_ready`). It is combinational from registered state and `ser_ready`; there is no path from `in_valid`.
- `in_data` is ignored whenever `in_ready`=0.
- `in_data` changes after acceptance do not affect the word in flight.
- Reset asserted mid-word aborts the word. No further bits of that word are emitted.

## Timing
- Acceptance at edge N gives the first bit valid in cycle N+1.
- Word throughput is 16 transfers. Back-to-back words with continuous `ser_ready`=1 give 16 valid bits per 16 cycles, with no bubble between words.
- Latency from acceptance to the last-bit transfer is exactly 16 cycles when `ser_ready`=1 throughout. Each cycle with `ser_ready`=0 adds one cycle.
- `ser_out`, `ser_valid` and `ser_last` depend only on registers, so none of them combinationally depends on `ser_ready` or `in_valid`.
- `in_ready` depends combinationally on `ser_ready` only.

## Structure
- Shared constants go in the common defines include:
  - `WORD_W`=16, `CNT_W`=4.
  - State encodings IDLE=1'b0 and SHIFT=1'b1.
- One sub-module: the existing `mux16_1`, instantiated once with `i`=`hold` and `s`=`cnt`. Its output drives `ser_out`, gated to 0 in IDLE.
- Counter and FSM are inline in `serializer16`; no further hierarchy.

## Test plan
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles, then `rst`=0 with `in_valid`=0.
  - Required: `in_ready`=1 and `ser_valid`=0 throughout.
- Single word, LSB first:
  - Stimulus: `in_data`=16'hA5C3 accepted, `ser_ready`=1.
  - Required: bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on 16 consecutive cycles, `ser_last` only on the 16th, then `ser_valid`=0.
- MSB first:
  - Stimulus: `MSB_FIRST`=1, `in_data`=16'h8001.
  - Required: first bit 1, bits 2–15 are 0, 16th bit 1 with `ser_last`=1.
- Back-pressure:
  - Stimulus: `ser_ready`=0 for 5 cycles after bit 3.
  - Required: `ser_out`, `ser_valid` and `cnt` stable during the stall; word completes 21 cycles after acceptance with all bits correct.
- Back-to-back:
  - Stimulus: `in_valid` held high with 16'hFFFF then 16'h0000.
  - Required: `in_ready`=1 in the last-bit cycle; 16 ones immediately followed by 16 zeros, with no gap.
- Reset mid-word:
  - Stimulus: assert `rst` after bit 7 of 16'h1234.
  - Required: next cycle `ser_valid`=0 and `in_ready`=1; a new word 16'h0F0F then serializes correctly from bit 0.

Source files
------------

// File: rtl/serializer16_pkg.sv
// ============================================================================
// serializer16_pkg : shared widths and state encoding for serializer16
// Rev 1.0
// ============================================================================
`default_nettype none

package serializer16_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit index where a word starts; the terminal index is the opposite end.
  function automatic logic [CNT_W-1:0] first_idx(input bit msb_first);
    return msb_first ? CNT_W'(WORD_W - 1) : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux16_1.sv
// ============================================================================
// mux16_1 : 16:1 single-bit select mux, o = i[s]
// Rev 1.0
// ============================================================================
`default_nettype none

module mux16_1 (
  input  logic [15:0] i,
  input  logic [3:0]  s,
  output logic        o
);

  assign o = i[s];

endmodule

`default_nettype wire

// File: rtl/serializer16.sv
// ============================================================================
// serializer16 : 16-bit parallel-to-serial stage with valid/ready on both sides
// Rev 1.0
// ============================================================================
`default_nettype none

module serializer16
  import serializer16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last
);

  localparam logic [CNT_W-1:0] FIRST_IDX = first_idx(MSB_FIRST);
  localparam logic [CNT_W-1:0] LAST_IDX  = first_idx(!MSB_FIRST);

  state_t            r_state;
  logic [WORD_W-1:0] r_hold;
  logic [CNT_W-1:0]  r_cnt;

  logic w_bit;
  logic w_at_last;
  logic w_accept;
  logic w_xfer;

  mux16_1 u_mux (
    .i (r_hold),
    .s (r_cnt),
    .o (w_bit)
  );

  assign w_at_last = (r_state == SHIFT) && (r_cnt == LAST_IDX);

  assign ser_valid = (r_state == SHIFT);
  assign ser_last  = w_at_last;
  assign ser_out   = ser_valid & w_bit;

  // Ready during the last-bit transfer lets the next word follow with no bubble.
  assign in_ready  = (r_state == IDLE) | (w_at_last & ser_ready);

  assign w_accept  = in_valid & in_ready;
  assign w_xfer    = ser_valid & ser_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_cnt   <= FIRST_IDX;
      r_hold  <= in_data;
    end else if (w_xfer) begin
      if (w_at_last) begin
        r_state <= IDLE;
      end else if (MSB_FIRST) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serializer16.sv
// ============================================================================
// tb_serializer16 : LSB-first and MSB-first instances checked against a bit-queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serializer16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        ser_ready;
  logic [15:0] in_data;

  logic l_irdy, l_out, l_valid, l_last;
  logic m_irdy, m_out, m_valid, m_last;

  int checks = 0;
  int errors = 0;

  // Expected serial streams of the word in flight, front = bit currently presented.
  bit q_lsb[$];
  bit q_msb[$];

  always #5 clk = ~clk;

  serializer16 #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(l_irdy),
    .ser_out(l_out), .ser_valid(l_valid), .ser_ready(ser_ready), .ser_last(l_last)
  );

  serializer16 #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_irdy),
    .ser_out(m_out), .ser_valid(m_valid), .ser_ready(ser_ready), .ser_last(m_last)
  );

  // Expected {valid, last, out, in_ready} for the current cycle.
  function automatic logic [3:0] exp_vec(input bit msb);
    int  n;
    bit  b;
    n = q_lsb.size();
    b = (n == 0) ? 1'b0 : (msb ? q_msb[0] : q_lsb[0]);
    return {n != 0, n == 1, b, (n == 0) || (n == 1 && ser_ready)};
  endfunction

  // Advance the model by one clock edge, then move to the next falling edge.
  task automatic tick();
    int n;
    bit rdy;
    n   = q_lsb.size();
    rdy = (n == 0) || (n == 1 && ser_ready);
    if (rst) begin
      q_lsb.delete();
      q_msb.delete();
    end else begin
      if (n != 0 && ser_ready) begin
        void'(q_lsb.pop_front());
        void'(q_msb.pop_front());
      end
      if (in_valid && rdy) begin
        for (int k = 0; k < 16; k++) begin
          q_lsb.push_back(in_data[k]);
          q_msb.push_back(in_data[15-k]);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] ev;
    rst = 1'b1; in_valid = 1'b0; ser_ready = 1'b1; in_data = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      ev = exp_vec(1'b0); checks++;
      if ({l_valid, l_last, l_out, l_irdy} !== ev || ev !== 4'b0001) begin
        errors++;
        $display("FAIL reset_idle lsb cyc %0d: got %b expected %b", c, {l_valid, l_last, l_out, l_irdy}, 4'b0001);
      end
      ev = exp_vec(1'b1); checks++;
      if ({m_valid, m_last, m_out, m_irdy} !== ev) begin
        errors++;
        $display("FAIL reset_idle msb cyc %0d: got %b expected %b", c, {m_valid, m_last, m_out, m_irdy}, ev);
      end
      tick();
    end
  endtask

  task automatic test_single_word(input logic [15:0] w, input string tag);
    logic [3:0]  ev;
    logic [15:0] got_l, got_m;
    int          k;
    got_l = '0; got_m = '0; k = 0;
    in_data = w; in_valid = 1'b1; ser_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 16'($urandom);
    for (int c = 0; c < 18; c++) begin
      #1;
      ev = exp_vec(1'b0); checks++;
      if ({l_valid, l_last, l_out, l_irdy} !== ev) begin
        errors++;
        $display("FAIL %s lsb cyc %0d: got %b expected %b", tag, c, {l_valid, l_last, l_out, l_irdy}, ev);
      end
      ev = exp_vec(1'b1); checks++;
      if ({m_valid, m_last, m_out, m_irdy} !== ev) begin
        errors++;
        $display("FAIL %s msb cyc %0d: got %b expected %b", tag, c, {m_valid, m_last, m_out, m_irdy}, ev);
      end
      if (l_valid === 1'b1 && k < 16) begin
        got_l[k]    = l_out;
        got_m[15-k] = m_out;
        k++;
      end
      in_data = 16'($urandom);
      tick();
    end
    checks++;
    if (got_l !== w || k != 16) begin
      errors++;
      $display("FAIL %s lsb_word: got %h (%0d bits) expected %h (16 bits)", tag, got_l, k, w);
    end
    checks++;
    if (got_m !== w) begin
      errors++;
      $display("FAIL %s msb_word: got %h expected %h", tag, got_m, w);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  ev;
    logic [15:0] w, got;
    logic [1:0]  held;
    int          n, k, lat;
    bit          done;
    w = 16'($urandom); got = '0; held = '0; n = 0; k = 0; lat = 0; done = 1'b0;
    in_data = w; in_valid = 1'b1; ser_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = ~w;
    while (!done && n < 40) begin
      ser_ready = !(n >= 3 && n < 8);
      #1;
      ev = exp_vec(1'b0); checks++;
      if ({l_valid, l_last, l_out, l_irdy} !== ev) begin
        errors++;
        $display("FAIL stall lsb cyc %0d: got %b expected %b", n, {l_valid, l_last, l_out, l_irdy}, ev);
      end
      ev = exp_vec(1'b1); checks++;
      if ({m_valid, m_last, m_out, m_irdy} !== ev) begin
        errors++;
        $display("FAIL stall msb cyc %0d: got %b expected %b", n, {m_valid, m_last, m_out, m_irdy}, ev);
      end
      if (n == 3) held = {l_out, l_valid};
      if (n > 3 && n < 8) begin
        checks++;
        if ({l_out, l_valid} !== held) begin
          errors++;
          $display("FAIL stall_hold cyc %0d: got %b expected %b", n, {l_out, l_valid}, held);
        end
      end
      if (l_valid === 1'b1 && ser_ready && k < 16) begin
        got[k] = l_out;
        k++;
        if (l_last === 1'b1) begin
          done = 1'b1;
          lat  = n + 1;
        end
      end
      tick();
      n++;
    end
    checks++;
    if (lat != 21) begin
      errors++;
      $display("FAIL stall_latency: got %0d expected 21", lat);
    end
    checks++;
    if (got !== w || k != 16) begin
      errors++;
      $display("FAIL stall_word: got %h (%0d bits) expected %h", got, k, w);
    end
    ser_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ev;
    logic [31:0] stream;
    int          nvalid;
    stream = '0; nvalid = 0;
    in_data = 16'hFFFF; in_valid = 1'b1; ser_ready = 1'b1;
    tick();
    in_data = 16'h0000;
    for (int c = 0; c < 33; c++) begin
      in_valid = (c < 16);
      #1;
      ev = exp_vec(1'b0); checks++;
      if ({l_valid, l_last, l_out, l_irdy} !== ev) begin
        errors++;
        $display("FAIL b2b lsb cyc %0d: got %b expected %b", c, {l_valid, l_last, l_out, l_irdy}, ev);
      end
      ev = exp_vec(1'b1); checks++;
      if ({m_valid, m_last, m_out, m_irdy} !== ev) begin
        errors++;
        $display("FAIL b2b msb cyc %0d: got %b expected %b", c, {m_valid, m_last, m_out, m_irdy}, ev);
      end
      if (c == 15) begin
        checks++;
        if ({l_last, l_irdy} !== 2'b11) begin
          errors++;
          $display("FAIL b2b_last_ready: got last,in_ready=%b expected 11", {l_last, l_irdy});
        end
      end
      if (c < 32) stream[c] = l_out;
      if (l_valid === 1'b1) nvalid++;
      tick();
    end
    checks++;
    if (stream !== 32'h0000_FFFF || nvalid != 32) begin
      errors++;
      $display("FAIL b2b_stream: got %h (%0d valid) expected 0000ffff (32 valid)", stream, nvalid);
    end
  endtask

  task automatic test_reset_mid_word();
    in_data = 16'h1234; in_valid = 1'b1; ser_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({l_valid, l_irdy, m_valid, m_irdy} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_abort: got valid,in_ready lsb=%b msb=%b expected 01", {l_valid, l_irdy}, {m_valid, m_irdy});
    end
    tick();
    test_single_word(16'h0F0F, "after_reset");
  endtask

  task automatic test_random();
    logic [3:0] ev;
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
      #1;
      ev = exp_vec(1'b0); checks++;
      if ({l_valid, l_last, l_out, l_irdy} !== ev) begin
        errors++;
        $display("FAIL random lsb cyc %0d: got %b expected %b", c, {l_valid, l_last, l_out, l_irdy}, ev);
      end
      ev = exp_vec(1'b1); checks++;
      if ({m_valid, m_last, m_out, m_irdy} !== ev) begin
        errors++;
        $display("FAIL random msb cyc %0d: got %b expected %b", c, {m_valid, m_last, m_out, m_irdy}, ev);
      end
      tick();
    end
    in_valid = 1'b0; ser_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
  endtask

  initial begin
    test_reset();
    test_single_word(16'hA5C3, "lsb_first");
    test_single_word(16'h8001, "msb_first");
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
